// File: rtl/i2c_target_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_pkg
//  Description : Shared definitions for the I2C register-port target:
//                FSM state encoding (4 bits, reported on status[3:0]),
//                status bit positions, ACK/NACK bus levels and the
//                majority-vote helper used by the optional glitch filter.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV_ADDR  = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_REG_PTR   = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WR_DATA   = 4'd5,
        ST_WR_ACK    = 4'd6,
        ST_RD_DATA   = 4'd7,
        ST_RD_ACK    = 4'd8,
        ST_WAIT_STOP = 4'd9
    } state_t;

    localparam int   c_STAT_MATCH_BIT = 4;
    localparam int   c_STAT_NACK_BIT  = 5;

    localparam logic c_ACK  = 1'b0;
    localparam logic c_NACK = 1'b1;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_bus_cond.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_cond
//  Description : Bus input conditioning. Two-flop synchronizers on SCL/SDA,
//                optional 3-sample majority filter (I2C_TARGET_GLITCH_FILTER_EN),
//                then single-cycle SCL rise/fall and START/STOP pulses.
//  Ports       : i_clk, i_rst      - clock, synchronous active-high reset
//                i_scl, i_sda      - raw asynchronous bus lines
//                o_sda             - conditioned SDA level
//                o_scl_rise/fall   - conditioned SCL edge pulses
//                o_start / o_stop  - bus condition pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_cond
    import i2c_target_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    // Idle bus is high; reset to 1 so leaving reset never fakes an edge.
    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       w_scl;
    logic       w_sda;
    logic       r_scl_d;
    logic       r_sda_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // A single-sample excursion never wins the 2-of-3 vote.
    logic [2:0] r_scl_hist;
    logic [2:0] r_sda_hist;
    logic       r_scl_flt;
    logic       r_sda_flt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_hist <= 3'b111;
            r_sda_hist <= 3'b111;
            r_scl_flt  <= 1'b1;
            r_sda_flt  <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[1:0], r_scl_sync[1]};
            r_sda_hist <= {r_sda_hist[1:0], r_sda_sync[1]};
            r_scl_flt  <= maj3(r_scl_hist);
            r_sda_flt  <= maj3(r_sda_hist);
        end
    end

    assign w_scl = r_scl_flt;
    assign w_sda = r_sda_flt;
`else
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    // START/STOP require SCL high on both sides of the SDA transition.
    assign o_sda      = w_sda;
    assign o_scl_rise =  w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl &  r_scl_d;
    assign o_start    =  w_scl &  r_scl_d &  r_sda_d & ~w_sda;
    assign o_stop     =  w_scl &  r_scl_d & ~r_sda_d &  w_sda;

endmodule
`default_nettype wire

// File: rtl/i2c_target_regport.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_regport
//  Description : I2C target answering one 7-bit address, exposing a
//                byte-addressed register space with auto-incrementing
//                pointer (pointer write, burst write, burst read).
//                Optional macro: I2C_TARGET_GLITCH_FILTER_EN (majority filter
//                on SCL/SDA; master low/high times must then be >= 6 clocks).
//  Ports       : i_clk, i_rst            - clock, sync active-high reset
//                i_scl, i_sda, o_sda_oe  - bus (open-drain SDA pull-down)
//                o_wr_en/addr/data       - one-cycle register write strobe
//                o_rd_req/addr, i_rd_data- read request, data one cycle later
//                o_busy                  - START..STOP
//                o_status                - {2'b0, nacked, matched, state}
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_regport
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h1D,
    parameter int         REG_AW   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_scl,
    input  logic              i_sda,
    output logic              o_sda_oe,
    output logic              o_wr_en,
    output logic [REG_AW-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_rd_req,
    output logic [REG_AW-1:0] o_rd_addr,
    input  logic [7:0]        i_rd_data,
    output logic              o_busy,
    output logic [7:0]        o_status
);

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_bus_cond u_bus_cond (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    state_t              r_state,     w_state_nxt;
    logic [3:0]          r_bit_cnt,   w_bit_cnt_nxt;
    logic [7:0]          r_shift,     w_shift_nxt;
    logic [7:0]          r_tx,        w_tx_nxt;
    logic [REG_AW-1:0]   r_ptr,       w_ptr_nxt;
    logic                r_rw,        w_rw_nxt;
    logic                r_sda_oe,    w_sda_oe_nxt;
    logic                r_busy,      w_busy_nxt;
    logic                r_wr_en,     w_wr_en_nxt;
    logic [REG_AW-1:0]   r_wr_addr,   w_wr_addr_nxt;
    logic [7:0]          r_wr_data,   w_wr_data_nxt;
    logic                r_rd_req,    w_rd_req_nxt;
    logic [REG_AW-1:0]   r_rd_addr,   w_rd_addr_nxt;
    logic                r_rd_pend;
    logic                r_matched,   w_matched_nxt;
    logic                r_nacked,    w_nacked_nxt;
    logic                w_addr_hit;

    // General call (0x00) is never acknowledged.
    assign w_addr_hit = (r_shift[7:1] == DEV_ADDR) && (r_shift[7:1] != 7'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'd0;
            r_tx      <= 8'd0;
            r_ptr     <= '0;
            r_rw      <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'd0;
            r_rd_req  <= 1'b0;
            r_rd_addr <= '0;
            r_rd_pend <= 1'b0;
            r_matched <= 1'b0;
            r_nacked  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_rw      <= w_rw_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_rd_req  <= w_rd_req_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_rd_pend <= r_rd_req;
            r_matched <= w_matched_nxt;
            r_nacked  <= w_nacked_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        // Read data returns the cycle after the request; capture it then.
        w_tx_nxt      = r_rd_pend ? i_rd_data : r_tx;
        w_ptr_nxt     = r_ptr;
        w_rw_nxt      = r_rw;
        w_sda_oe_nxt  = r_sda_oe;
        w_busy_nxt    = r_busy;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_rd_req_nxt  = 1'b0;
        w_rd_addr_nxt = r_rd_addr;
        w_matched_nxt = r_matched;
        w_nacked_nxt  = r_nacked;

        // Bus conditions outrank any SCL edge seen in the same cycle.
        if (w_stop) begin
            w_state_nxt  = ST_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (w_start) begin
            w_state_nxt   = ST_DEV_ADDR;
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: ;
                ST_DEV_ADDR, ST_REG_PTR, ST_WR_DATA: begin
                    if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
                        w_shift_nxt   = {r_shift[6:0], w_sda};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                        w_bit_cnt_nxt = 4'd0;
                        if (r_state == ST_DEV_ADDR) begin
                            w_matched_nxt = w_addr_hit;
                            if (w_addr_hit) begin
                                w_state_nxt  = ST_ADDR_ACK;
                                w_sda_oe_nxt = 1'b1;
                                w_rw_nxt     = r_shift[0];
                                if (r_shift[0]) begin
                                    w_rd_req_nxt  = 1'b1;
                                    w_rd_addr_nxt = r_ptr;
                                end
                            end else begin
                                w_state_nxt  = ST_WAIT_STOP;
                                w_sda_oe_nxt = 1'b0;
                            end
                        end else if (r_state == ST_REG_PTR) begin
                            w_ptr_nxt    = REG_AW'(r_shift);
                            w_sda_oe_nxt = 1'b1;
                            w_state_nxt  = ST_PTR_ACK;
                        end else begin
                            w_wr_en_nxt   = 1'b1;
                            w_wr_addr_nxt = r_ptr;
                            w_wr_data_nxt = r_shift;
                            w_ptr_nxt     = r_ptr + REG_AW'(1);
                            w_sda_oe_nxt  = 1'b1;
                            w_state_nxt   = ST_WR_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_rw) begin
                            // The falling edge that ends the ACK also
                            // presents the first data bit.
                            w_state_nxt   = ST_RD_DATA;
                            w_sda_oe_nxt  = ~r_tx[7];
                            w_tx_nxt      = {r_tx[6:0], 1'b0};
                            w_bit_cnt_nxt = 4'd1;
                        end else begin
                            w_state_nxt   = ST_REG_PTR;
                            w_sda_oe_nxt  = 1'b0;
                            w_bit_cnt_nxt = 4'd0;
                        end
                    end
                end
                ST_PTR_ACK, ST_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_state_nxt   = ST_WR_DATA;
                        w_sda_oe_nxt  = 1'b0;
                        w_bit_cnt_nxt = 4'd0;
                    end
                end
                ST_RD_DATA: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_sda_oe_nxt = 1'b0;
                            w_ptr_nxt    = r_ptr + REG_AW'(1);
                            w_state_nxt  = ST_RD_ACK;
                        end else begin
                            w_sda_oe_nxt  = ~r_tx[7];
                            w_tx_nxt      = {r_tx[6:0], 1'b0};
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda == c_ACK) begin
                            w_rd_req_nxt  = 1'b1;
                            w_rd_addr_nxt = r_ptr;
                            w_nacked_nxt  = 1'b0;
                            w_bit_cnt_nxt = 4'd0;
                            w_state_nxt   = ST_RD_DATA;
                        end else begin
                            w_nacked_nxt = 1'b1;
                            w_state_nxt  = ST_WAIT_STOP;
                        end
                    end
                end
                ST_WAIT_STOP: w_sda_oe_nxt = 1'b0;
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // Gate with reset so SDA is released in the very cycle reset is applied.
    assign o_sda_oe  = r_sda_oe & ~i_rst;
    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_rd_req  = r_rd_req;
    assign o_rd_addr = r_rd_addr;
    assign o_busy    = r_busy;
    assign o_status  = {2'b00, r_nacked, r_matched, r_state};

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_target_regport
//  Description : Self-checking bench for i2c_target_regport. A bus master
//                model drives SCL/SDA; expected strobes and received bytes
//                are queued by the stimulus and popped by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_target_regport;

    localparam int Q = 6;    // SCL low half: data change point
    localparam int H = 10;   // SCL high time

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl, m_sda;
    logic       w_bus_sda;
    logic       o_sda_oe, o_wr_en, o_rd_req, o_busy;
    logic [7:0] o_wr_addr, o_wr_data, o_rd_addr, o_status;
    logic [7:0] r_host_rd;

    int n_checks = 0;
    int n_pass   = 0;
    int n_oe_cycles = 0;
    int oe_snap;
    logic v_ack, v_bit;

    logic [15:0] wr_exp_q[$];
    logic [7:0]  rd_exp_q[$];
    logic [7:0]  rx_exp_q[$];
    logic [7:0]  rx_obs_q[$];

    always #5 clk = ~clk;

    assign w_bus_sda = m_sda & ~o_sda_oe;

    // Host register model: data for the requested address, one cycle later.
    always_ff @(posedge clk)
        if (o_rd_req) r_host_rd <= 8'hA0 + (o_rd_addr - 8'h06);

    i2c_target_regport #(.DEV_ADDR(7'h1D), .REG_AW(8)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_scl     (m_scl),
        .i_sda     (w_bus_sda),
        .o_sda_oe  (o_sda_oe),
        .o_wr_en   (o_wr_en),
        .o_wr_addr (o_wr_addr),
        .o_wr_data (o_wr_data),
        .o_rd_req  (o_rd_req),
        .o_rd_addr (o_rd_addr),
        .i_rd_data (r_host_rd),
        .o_busy    (o_busy),
        .o_status  (o_status)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(H);
        m_sda = 1'b0; wait_clk(H);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(H);
        m_sda = 1'b1; wait_clk(H);
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        m_sda = b; wait_clk(Q);
        m_scl = 1'b1;
        if (glitch) begin
            wait_clk(H/2); m_scl = 1'b0;
            wait_clk(1);   m_scl = 1'b1;
            wait_clk(H - H/2 - 1);
        end else begin
            wait_clk(H);
        end
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(H/2);
        b = w_bus_sda;
        wait_clk(H - H/2);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic send_ack);
        logic [7:0] d;
        logic       b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        rx_obs_q.push_back(d);
        write_bit(send_ack ? 1'b0 : 1'b1, 1'b0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe or the
    // master model has received a byte.
    initial begin
        forever begin
            @(negedge clk);
            if (o_sda_oe) n_oe_cycles++;
            if (o_wr_en && o_rd_req) check("wr_rd_overlap", 32'd1, 32'd0);
            if (o_wr_en) begin
                if (wr_exp_q.size() == 0) check("wr_en_unexpected", {24'd0, o_wr_addr}, 32'hFFFF_FFFF);
                else check("wr_strobe", {16'd0, o_wr_addr, o_wr_data}, {16'd0, wr_exp_q.pop_front()});
            end
            if (o_rd_req) begin
                if (rd_exp_q.size() == 0) check("rd_req_unexpected", {24'd0, o_rd_addr}, 32'hFFFF_FFFF);
                else check("rd_req_addr", {24'd0, o_rd_addr}, {24'd0, rd_exp_q.pop_front()});
            end
            while (rx_obs_q.size() > 0) begin
                if (rx_exp_q.size() == 0) check("rx_unexpected", {24'd0, rx_obs_q.pop_front()}, 32'hFFFF_FFFF);
                else check("rx_byte", {24'd0, rx_obs_q.pop_front()}, {24'd0, rx_exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
        wait_clk(5);
        @(negedge clk);
        check("reset_sda_oe",  {31'd0, o_sda_oe}, 32'd0);
        check("reset_busy",    {31'd0, o_busy}, 32'd0);
        check("reset_status",  {24'd0, o_status}, 32'd0);
        check("reset_strobes", {30'd0, o_wr_en, o_rd_req}, 32'd0);
        check("reset_addrs",   {8'd0, o_wr_addr, o_wr_data, o_rd_addr}, 32'd0);
        rst = 1'b0;
        wait_clk(5);

        // Single register write 0x2D <= 0x02
        wr_exp_q.push_back({8'h2D, 8'h02});
        i2c_start();
        write_byte({7'h1D, 1'b0}, -1, v_ack); check("t1_addr_ack", {31'd0, v_ack}, 32'd0);
        check("t1_busy_mid", {31'd0, o_busy}, 32'd1);
        write_byte(8'h2D, -1, v_ack); check("t1_ptr_ack", {31'd0, v_ack}, 32'd0);
        write_byte(8'h02, -1, v_ack); check("t1_data_ack", {31'd0, v_ack}, 32'd0);
        i2c_stop();
        wait_clk(8);
        check("t1_busy_after_stop", {31'd0, o_busy}, 32'd0);
        check("t1_status_idle", {24'd0, o_status}, 32'h10);

        // Pointer 0x06, repeated start, 11-byte burst read
        i2c_start();
        write_byte({7'h1D, 1'b0}, -1, v_ack); check("t2_addr_ack", {31'd0, v_ack}, 32'd0);
        write_byte(8'h06, -1, v_ack); check("t2_ptr_ack", {31'd0, v_ack}, 32'd0);
        i2c_start();
        for (int i = 0; i < 11; i++) begin
            rd_exp_q.push_back(8'h06 + 8'(i));
            rx_exp_q.push_back(8'hA0 + 8'(i));
        end
        write_byte({7'h1D, 1'b1}, -1, v_ack); check("t2_raddr_ack", {31'd0, v_ack}, 32'd0);
        for (int i = 0; i < 11; i++) read_byte(i < 10);
        wait_clk(2);
        check("t2_sda_released", {31'd0, o_sda_oe}, 32'd0);
        check("t2_status_nack_wait", {24'd0, o_status}, 32'h39);
        i2c_stop();
        wait_clk(8);

        // Foreign address 0x53: never driven, no write, no match
        oe_snap = n_oe_cycles;
        i2c_start();
        write_byte({7'h53, 1'b0}, -1, v_ack); check("t3_addr_nack", {31'd0, v_ack}, 32'd1);
        write_byte(8'h44, -1, v_ack); check("t3_data_nack", {31'd0, v_ack}, 32'd1);
        i2c_stop();
        wait_clk(8);
        check("t3_no_sda_drive", 32'(n_oe_cycles - oe_snap), 32'd0);
        check("t3_status_match", {31'd0, o_status[4]}, 32'd0);

        // STOP after 5 data bits discards the byte; next transfer normal
        i2c_start();
        write_byte({7'h1D, 1'b0}, -1, v_ack); check("t4_addr_ack", {31'd0, v_ack}, 32'd0);
        write_byte(8'h10, -1, v_ack); check("t4_ptr_ack", {31'd0, v_ack}, 32'd0);
        write_bit(1'b1, 1'b0); write_bit(1'b0, 1'b0); write_bit(1'b1, 1'b0);
        write_bit(1'b0, 1'b0); write_bit(1'b1, 1'b0);
        i2c_stop();
        wait_clk(8);
        check("t4_state_idle", {28'd0, o_status[3:0]}, 32'd0);
        check("t4_busy_low", {31'd0, o_busy}, 32'd0);
        wr_exp_q.push_back({8'h20, 8'h55});
        i2c_start();
        write_byte({7'h1D, 1'b0}, -1, v_ack); check("t4b_addr_ack", {31'd0, v_ack}, 32'd0);
        write_byte(8'h20, -1, v_ack); check("t4b_ptr_ack", {31'd0, v_ack}, 32'd0);
        write_byte(8'h55, -1, v_ack); check("t4b_data_ack", {31'd0, v_ack}, 32'd0);
        i2c_stop();
        wait_clk(8);

        // Pointer wrap 0xFF -> 0x00
        wr_exp_q.push_back({8'hFF, 8'h11});
        wr_exp_q.push_back({8'h00, 8'h22});
        i2c_start();
        write_byte({7'h1D, 1'b0}, -1, v_ack);
        write_byte(8'hFF, -1, v_ack);
        write_byte(8'h11, -1, v_ack); check("t5_data0_ack", {31'd0, v_ack}, 32'd0);
        write_byte(8'h22, -1, v_ack); check("t5_data1_ack", {31'd0, v_ack}, 32'd0);
        i2c_stop();
        wait_clk(8);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // One-clock SCL low pulse inside a data bit must not add a bit
        wr_exp_q.push_back({8'h30, 8'hC3});
        i2c_start();
        write_byte({7'h1D, 1'b0}, -1, v_ack);
        write_byte(8'h30, -1, v_ack);
        write_byte(8'hC3, 3, v_ack); check("t6_glitch_ack", {31'd0, v_ack}, 32'd0);
        i2c_stop();
        wait_clk(8);
`endif

        // Reset while the target drives a 0 data bit
        i2c_start();
        write_byte({7'h1D, 1'b0}, -1, v_ack);
        write_byte(8'h06, -1, v_ack);
        i2c_start();
        rd_exp_q.push_back(8'h06);
        write_byte({7'h1D, 1'b1}, -1, v_ack); check("t7_raddr_ack", {31'd0, v_ack}, 32'd0);
        read_bit(v_bit); check("t7_bit7", {31'd0, v_bit}, 32'd1);
        wait_clk(2);
        check("t7_driving_zero", {31'd0, o_sda_oe}, 32'd1);
        check("t7_state_rd_data", {28'd0, o_status[3:0]}, 32'd7);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t7_sda_release_on_reset", {31'd0, o_sda_oe}, 32'd0);
        @(negedge clk);
        check("t7_reset_outputs", {27'd0, o_sda_oe, o_wr_en, o_rd_req, o_busy, 1'b0}, 32'd0);
        check("t7_reset_status", {24'd0, o_status}, 32'd0);
        rst = 1'b0;
        m_scl = 1'b1; wait_clk(H);
        m_sda = 1'b1; wait_clk(H);

        // Pointer is back at 0 after reset: data = 0xA0 + (0 - 6) = 0x9A
        rd_exp_q.push_back(8'h00);
        rx_exp_q.push_back(8'h9A);
        i2c_start();
        write_byte({7'h1D, 1'b1}, -1, v_ack); check("t8_raddr_ack", {31'd0, v_ack}, 32'd0);
        read_byte(1'b0);
        i2c_stop();
        wait_clk(10);

        check("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        check("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
